// File: rtl/fm_modulate.sv
`default_nettype none
// ============================================================================
// Module      : fm_modulate
// Description : FM modulator for the transmit path. Signed audio samples are
//               scaled by 2^GAIN_SHIFT with saturation to 16 bits. The result
//               is the instantaneous frequency deviation. That deviation, plus
//               CARRIER_INC, is integrated into a wrapping 16-bit phase
//               accumulator. The output is an AXI-Stream word of the form
//               {phase[15:0], MAGNITUDE[15:0]}.
//
//               Two-stage pipeline:
//                 stage 1 - sample capture, gain shift and saturation
//                 stage 2 - phase accumulation and output register
//               Both stages advance together on en = tready || !tvalid.
//
// Ports       : s00_axis_aclk    - clock, all logic on the rising edge
//               s00_axis_areset  - synchronous reset, active-high
//               s00_axis_tvalid  - input sample valid
//               s00_axis_tdata   - [15:0] signed audio sample, upper bits unused
//               s00_axis_tstrb   - forwarded alongside the sample
//               s00_axis_tlast   - forwarded alongside the sample
//               s00_axis_tready  - pipeline enable (combinational)
//               sw               - mode select (test-tone build only)
//               m00_axis_tready  - downstream ready
//               m00_axis_tvalid  - output valid
//               m00_axis_tdata   - {phase, MAGNITUDE}
//               m00_axis_tstrb   - delayed input tstrb
//               m00_axis_tlast   - delayed input tlast
//
// Build option: FM_TEST_TONE_EN - when this macro is defined and sw == 4'd3,
//               the sample source is an internal 16-bit counter. The counter
//               starts at 0 and advances by 1 per accepted input beat.
//
// Revision    : 1.0 - initial release
// ============================================================================
module fm_modulate #(
  parameter int          C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int          C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int          GAIN_SHIFT             = 1,
  parameter logic [15:0] CARRIER_INC            = 16'h0000,
  parameter logic [15:0] MAGNITUDE              = 16'h7FFF
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_areset,
  input  logic                                  s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  input  logic                                  s00_axis_tlast,
  output logic                                  s00_axis_tready,
  input  logic [3:0]                            sw,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                  m00_axis_tlast
);

  localparam int C_SW = C_S00_AXIS_TDATA_WIDTH / 8;
  localparam int C_MW = C_M00_AXIS_TDATA_WIDTH / 8;

  // Pipeline enable: both stages move whenever the output slot is free or
  // is being drained this cycle.
  logic w_en;
  assign w_en            = m00_axis_tready || !m00_axis_tvalid;
  assign s00_axis_tready = w_en;

  // --------------------------------------------------------------------------
  // Sample source select
  // --------------------------------------------------------------------------
  logic [15:0] w_sample;

`ifdef FM_TEST_TONE_EN
  logic [15:0] tone_cnt_q, tone_cnt_d;

  assign w_sample   = (sw == 4'd3) ? tone_cnt_q : s00_axis_tdata[15:0];
  assign tone_cnt_d = (w_en && s00_axis_tvalid) ? tone_cnt_q + 16'd1 : tone_cnt_q;

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      tone_cnt_q <= 16'd0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
    end
  end

  logic w_unused;
  assign w_unused = ^s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:16];
`else
  assign w_sample = s00_axis_tdata[15:0];

  logic w_unused;
  assign w_unused = ^{sw, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:16]};
`endif

  // --------------------------------------------------------------------------
  // Gain shift with saturation. The sample is sign-extended to 24 bits first.
  // 24 bits is enough headroom for the largest shift (8), so no overflow
  // can occur before the clamp.
  // --------------------------------------------------------------------------
  logic signed [23:0] w_wide;
  logic        [15:0] w_dev_sat;

  assign w_wide = $signed({{8{w_sample[15]}}, w_sample}) <<< GAIN_SHIFT;

  always_comb begin
    w_dev_sat = w_wide[15:0];
    if (w_wide > 24'sd32767) begin
      w_dev_sat = 16'h7FFF;
    end else if (w_wide < -24'sd32768) begin
      w_dev_sat = 16'h8000;
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic                              v1_q,     v1_d;
  logic [15:0]                       dev1_q,   dev1_d;
  logic [C_SW-1:0]                   strb1_q,  strb1_d;
  logic                              last1_q,  last1_d;
  logic [15:0]                       phase_q,  phase_d;
  logic                              tvalid_q, tvalid_d;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_q,  tdata_d;
  logic [C_MW-1:0]                   tstrb_q,  tstrb_d;
  logic                              tlast_q,  tlast_d;

  // Deviation is treated as two's complement. Modular 16-bit addition wraps
  // the phase through 2*pi in either direction.
  logic [15:0] w_phase_sum;
  assign w_phase_sum = phase_q + dev1_q + CARRIER_INC;

  always_comb begin
    v1_d     = v1_q;
    dev1_d   = dev1_q;
    strb1_d  = strb1_q;
    last1_d  = last1_q;
    phase_d  = phase_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tstrb_d  = tstrb_q;
    tlast_d  = tlast_q;

    if (w_en) begin
      // Stage 1
      v1_d = s00_axis_tvalid;
      if (s00_axis_tvalid) begin
        dev1_d  = w_dev_sat;
        strb1_d = s00_axis_tstrb;
        last1_d = s00_axis_tlast;
      end

      // Stage 2: bubbles leave the accumulator untouched.
      tvalid_d = v1_q;
      if (v1_q) begin
        phase_d = w_phase_sum;
        tdata_d = C_M00_AXIS_TDATA_WIDTH'({w_phase_sum, MAGNITUDE});
        tstrb_d = C_MW'(strb1_q);
        tlast_d = last1_q;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      v1_q     <= 1'b0;
      dev1_q   <= 16'd0;
      strb1_q  <= '0;
      last1_q  <= 1'b0;
      phase_q  <= 16'd0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      dev1_q   <= dev1_d;
      strb1_q  <= strb1_d;
      last1_q  <= last1_d;
      phase_q  <= phase_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tstrb_q  <= tstrb_d;
      tlast_q  <= tlast_d;
    end
  end

  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tstrb  = tstrb_q;
  assign m00_axis_tlast  = tlast_q;

endmodule
`default_nettype wire

// File: tb/tb_fm_modulate.sv
`default_nettype none
// ============================================================================
// Module      : tb_fm_modulate
// Description : Directed self-checking bench for fm_modulate with default
//               parameters (GAIN_SHIFT=1, CARRIER_INC=0, MAGNITUDE=0x7FFF).
//               Inputs change 1 ns after the rising edge. Outputs are
//               observed on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_modulate;

  logic        clk;
  logic        areset;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tlast;
  logic        s_tready;
  logic [3:0]  sw;
  logic        m_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tlast;

  int n_checks = 0;
  int n_fail   = 0;

  // Accepted output beats: {tlast, tstrb, tdata}
  logic [36:0] out_q[$];

  fm_modulate dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (areset),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tstrb  (s_tstrb),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tready (s_tready),
    .sw              (sw),
    .m00_axis_tready (m_tready),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb),
    .m00_axis_tlast  (m_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record each beat whose handshake completes on the coming rising edge.
  always @(negedge clk) begin
    if (!areset && m_tvalid && m_tready) out_q.push_back({m_tlast, m_tstrb, m_tdata});
  end

  // All tasks start and end 1 ns after a rising edge.
  task automatic apply_reset();
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tstrb  = 4'h0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    areset = 1'b0;
    out_q.delete();
  endtask

  task automatic send(input logic [31:0] data, input logic last, input logic [3:0] strb);
    int cnt = 0;
    s_tvalid = 1'b1;
    s_tdata  = data;
    s_tlast  = last;
    s_tstrb  = strb;
    @(negedge clk);
    while (s_tready !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: s00_axis_tready stuck at %b, required 1", s_tready);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int cnt = 0;
    while (out_q.size() < n && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (out_q.size() < n) begin
      n_fail++;
      $display("FAIL output_count: got %0d beats, required %0d", out_q.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    // Park one beat in the output register with downstream stalled.
    m_tready = 1'b0;
    send(32'h0000_1234, 1'b1, 4'hF);
    @(posedge clk);
    #1;
    n_checks++;
    if (m_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prefill_valid: tvalid=%b, required 1", m_tvalid);
    end
    // A mid-stream reset must drop the stalled beat.
    areset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tlast !== 1'b0 || m_tstrb !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: tvalid=%b tdata=%h tlast=%b tstrb=%h, required 0 0 0 0",
               m_tvalid, m_tdata, m_tlast, m_tstrb);
    end
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: tready=%b tvalid=%b, required 1 0", s_tready, m_tvalid);
    end
    @(posedge clk);
    #1;
    out_q.delete();
    m_tready = 1'b1;
    // The accumulator restarts from 0 after reset.
    send(32'h0000_0100, 1'b0, 4'hF);
    wait_outputs(1);
    n_checks++;
    if (out_q.size() < 1 || out_q[0][31:0] !== 32'h0200_7FFF) begin
      n_fail++;
      $display("FAIL reset_first_phase: tdata=%h, required 02007fff",
               (out_q.size() > 0) ? out_q[0][31:0] : 32'hx);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_ramp();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h0200_7FFF;
    exp_d[1] = 32'h0400_7FFF;
    exp_d[2] = 32'h0600_7FFF;
    exp_d[3] = 32'h0800_7FFF;
    apply_reset();
    send(32'h0000_0100, 1'b0, 4'hF);
    // The beat is in stage 1 now. It must not be visible yet.
    @(negedge clk);
    n_checks++;
    if (m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_latency_early: tvalid=%b one edge after accept, required 0", m_tvalid);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h0200_7FFF) begin
      n_fail++;
      $display("FAIL ramp_latency: tvalid=%b tdata=%h, required 1 02007fff", m_tvalid, m_tdata);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(32'h0000_0100, 1'b0, 4'hF);
    wait_outputs(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_q.size() <= i || out_q[i][31:0] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL ramp_beat%0d: tdata=%h, required %h", i,
                 (out_q.size() > i) ? out_q[i][31:0] : 32'hx, exp_d[i]);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_wrap_sat();
    logic [31:0] din [5];
    logic [15:0] exp_p [5];
    din[0] = 32'h0000_4000;  exp_p[0] = 16'h7FFF;  // 0x8000 clamps to +32767
    din[1] = 32'h0000_4000;  exp_p[1] = 16'hFFFE;
    din[2] = 32'h0000_4000;  exp_p[2] = 16'h7FFD;  // wraps
    din[3] = 32'hABCD_8000;  exp_p[3] = 16'hFFFD;  // -65536 clamps to -32768
    din[4] = 32'h0000_FF00;  exp_p[4] = 16'hFDFD;  // -256 * 2 = -512
    apply_reset();
    for (int i = 0; i < 5; i++) send(din[i], 1'b0, 4'hF);
    wait_outputs(5);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_q.size() <= i || out_q[i][31:0] !== {exp_p[i], 16'h7FFF}) begin
        n_fail++;
        $display("FAIL wrap_sat_beat%0d: tdata=%h, required %h", i,
                 (out_q.size() > i) ? out_q[i][31:0] : 32'hx, {exp_p[i], 16'h7FFF});
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_framing();
    logic [36:0] exp;
    apply_reset();
    for (int k = 0; k < 8; k++) send(32'h0000_0010, (k == 7), 4'hF);
    send(32'h0000_0010, 1'b0, 4'h3);
    send(32'h0000_0010, 1'b0, 4'h3);
    wait_outputs(10);
    for (int k = 0; k < 10; k++) begin
      exp = {(k == 7), (k < 8) ? 4'hF : 4'h3, 16'(32 * (k + 1)), 16'h7FFF};
      n_checks++;
      if (out_q.size() <= k || out_q[k] !== exp) begin
        n_fail++;
        $display("FAIL framing_beat%0d: {last,strb,data}=%h, required %h", k,
                 (out_q.size() > k) ? out_q[k] : 37'hx, exp);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [31:0] samples [64];
    logic [31:0] exp_d   [64];
    int          phase = 0;
    int          dev;
    int          idx   = 0;
    int          cyc   = 0;
    logic        saved_valid = 1'b0;
    logic [31:0] saved_data  = 32'h0;
    for (int i = 0; i < 64; i++) begin
      samples[i] = $urandom;
      dev = int'($signed(samples[i][15:0])) * 2;
      if (dev > 32767)  dev = 32767;
      if (dev < -32768) dev = -32768;
      phase = (phase + dev) & 16'hFFFF;
      exp_d[i] = {phase[15:0], 16'h7FFF};
    end
    apply_reset();
    while (out_q.size() < 64 && cyc < 3000) begin
      m_tready = ($urandom_range(0, 2) != 0);
      if (idx < 64) begin
        s_tvalid = ($urandom_range(0, 3) != 0);
        s_tdata  = samples[idx];
        s_tstrb  = 4'hF;
        s_tlast  = 1'b0;
      end else begin
        s_tvalid = 1'b0;
      end
      @(negedge clk);
      if (saved_valid) begin
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== saved_data) begin
          n_fail++;
          $display("FAIL stall_stable: tvalid=%b tdata=%h, required 1 %h", m_tvalid, m_tdata, saved_data);
        end
      end
      saved_valid = m_tvalid && !m_tready;
      saved_data  = m_tdata;
      if (s_tvalid && s_tready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    n_checks++;
    if (out_q.size() != 64) begin
      n_fail++;
      $display("FAIL bp_count: got %0d beats, required 64", out_q.size());
    end
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (out_q.size() <= i || out_q[i][31:0] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL bp_beat%0d: tdata=%h, required %h", i,
                 (out_q.size() > i) ? out_q[i][31:0] : 32'hx, exp_d[i]);
      end
    end
  endtask

`ifdef FM_TEST_TONE_EN
  // --------------------------------------------------------------------------
  // Counter source 0,1,2,3,4 with gain x2 gives phases 0,2,6,12,20.
  task automatic test_test_tone();
    logic [15:0] exp_p [5];
    exp_p[0] = 16'd0;
    exp_p[1] = 16'd2;
    exp_p[2] = 16'd6;
    exp_p[3] = 16'd12;
    exp_p[4] = 16'd20;
    apply_reset();
    sw = 4'd3;
    for (int i = 0; i < 5; i++) send(32'h0000_5555, 1'b0, 4'hF);
    wait_outputs(5);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_q.size() <= i || out_q[i][31:16] !== exp_p[i]) begin
        n_fail++;
        $display("FAIL tone_beat%0d: phase=%h, required %h", i,
                 (out_q.size() > i) ? out_q[i][31:16] : 16'hx, exp_p[i]);
      end
    end
    sw = 4'd0;
  endtask
`endif

  initial begin
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = 32'h0;
    s_tstrb  = 4'h0;
    s_tlast  = 1'b0;
    sw       = 4'd0;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_ramp();
    test_wrap_sat();
    test_framing();
    test_backpressure();
`ifdef FM_TEST_TONE_EN
    test_test_tone();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
